// File: rtl/edge_det_pkg.sv
// Shared types and sizing helpers for the multi-channel edge detector.
package edge_det_pkg;

  typedef enum logic [1:0] {
    MODE_RISE = 2'b00,
    MODE_FALL = 2'b01,
    MODE_BOTH = 2'b10,
    MODE_OFF  = 2'b11
  } mode_e;

  // Debounce counter must hold DEBOUNCE_CYCLES-1 with one bit of headroom.
  function automatic int unsigned dcnt_width(input int unsigned cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/edge_det_channel.sv
// One channel: synchroniser, debounce filter, mode-qualified edge pulse,
// sticky event flag and saturating edge counter.
module edge_det_channel
  import edge_det_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             data_in,
  input  logic [1:0]       mode,
  input  logic             clear,
  output logic             level,
  output logic             pulse,
  output logic             event_flag,
  output logic [CNT_W-1:0] edge_count,
  output logic             pulse_d_c
);

  localparam int unsigned           DCNT_W   = dcnt_width(DEBOUNCE_CYCLES);
  localparam logic [DCNT_W-1:0]     DCNT_MAX = DCNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]      CNT_SAT  = '1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DCNT_W-1:0]      dcnt_q, dcnt_d;
  logic                   level_q, level_d;
  logic                   pulse_q, pulse_d;
  logic                   flag_q, flag_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   s, accept, rise, fall;
  mode_e                  mode_sel;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], data_in};
    s        = sync_q[SYNC_STAGES-1];
    mode_sel = mode_e'(mode);
    level_d  = level_q;
    dcnt_d   = dcnt_q + DCNT_W'(1);
    accept   = 1'b0;
    rise     = s & ~level_q;
    fall     = ~s & level_q;

    // A return to the current level before the count completes restarts it.
    if (s == level_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == DCNT_MAX) begin
      level_d = s;
      dcnt_d  = '0;
      accept  = 1'b1;
    end

    pulse_d = accept & (((mode_sel == MODE_RISE) & rise) |
                        ((mode_sel == MODE_FALL) & fall) |
                        ((mode_sel == MODE_BOTH) & (rise | fall)));

    // Set wins over clear so a coincident event is never lost.
    flag_d = flag_q;
    if (pulse_d)    flag_d = 1'b1;
    else if (clear) flag_d = 1'b0;

    cnt_d = cnt_q;
    if (clear && pulse_d)                  cnt_d = CNT_W'(1);
    else if (clear)                        cnt_d = '0;
    else if (pulse_d && (cnt_q != CNT_SAT)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q  <= '0;
      dcnt_q  <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      flag_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      dcnt_q  <= dcnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      flag_q  <= flag_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level      = level_q;
  assign pulse      = pulse_q;
  assign event_flag = flag_q;
  assign edge_count = cnt_q;
  assign pulse_d_c  = pulse_d;

endmodule

// File: rtl/multi_edge_detector.sv
// NUM_CH independent edge-detector channels plus a registered any-pulse
// summary aligned with the per-channel pulses.
module multi_edge_detector
  import edge_det_pkg::*;
#(
  parameter int unsigned NUM_CH          = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_CH-1:0]       data_in,
  input  logic [2*NUM_CH-1:0]     mode,
  input  logic [NUM_CH-1:0]       clear,
  output logic [NUM_CH-1:0]       level,
  output logic [NUM_CH-1:0]       pulse,
  output logic [NUM_CH-1:0]       event_flag,
  output logic [CNT_W*NUM_CH-1:0] edge_count,
  output logic                    any_pulse
);

  logic [NUM_CH-1:0] pulse_nxt;
  logic              any_pulse_q, any_pulse_d;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    edge_det_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .data_in   (data_in[i]),
      .mode      (mode[2*i +: 2]),
      .clear     (clear[i]),
      .level     (level[i]),
      .pulse     (pulse[i]),
      .event_flag(event_flag[i]),
      .edge_count(edge_count[CNT_W*i +: CNT_W]),
      .pulse_d_c (pulse_nxt[i])
    );
  end

  // Built from next-state pulses so it lands in the same cycle as pulse.
  always_comb begin
    any_pulse_d = |pulse_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) any_pulse_q <= 1'b0;
    else          any_pulse_q <= any_pulse_d;
  end

  assign any_pulse = any_pulse_q;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench: expected pulse events are queued by the stimulus and
// checked by an independent monitor whenever the DUT reports a pulse.
module tb_multi_edge_detector;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] data_in;
  logic [7:0] mode;
  logic [3:0] clear;
  logic [3:0] level, pulse, event_flag;
  logic [7:0] edge_count;
  logic       any_pulse;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    int         cyc;
    logic [3:0] pulse;
    logic [3:0] flag;
    logic [3:0] level;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  multi_edge_detector #(
    .NUM_CH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_W(2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .data_in   (data_in),
    .mode      (mode),
    .clear     (clear),
    .level     (level),
    .pulse     (pulse),
    .event_flag(event_flag),
    .edge_count(edge_count),
    .any_pulse (any_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] p, input logic [3:0] f, input logic [3:0] l,
                      input logic [7:0] c, input int lat);
    exp_t e;
    e.cyc = cyc + lat; e.pulse = p; e.flag = f; e.level = l; e.cnt = c;
    exp_q.push_back(e);
  endtask

  // Monitor: any reported pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (any_pulse || (pulse != 4'h0)) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL mon_unexpected: got pulse 0x%0h any %0b expected none (cycle %0d)",
                 pulse, any_pulse, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mon_cycle", 32'(cyc), 32'(e.cyc));
        chk("mon_pulse", 32'(pulse), 32'(e.pulse));
        chk("mon_any_pulse", 32'(any_pulse), 32'd1);
        chk("mon_level", 32'(level), 32'(e.level));
        chk("mon_event_flag", 32'(event_flag), 32'(e.flag));
        chk("mon_edge_count", 32'(edge_count), 32'(e.cnt));
      end
    end
  end

  initial begin
    reset_n = 1'b0; data_in = 4'h0; mode = 8'h00; clear = 4'h0;
    wait_cyc(3);
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_pulse", 32'(pulse), 32'h0);
    chk("rst_flag", 32'(event_flag), 32'h0);
    chk("rst_count", 32'(edge_count), 32'h0);
    chk("rst_any", 32'(any_pulse), 32'h0);
    reset_n = 1'b1;
    mode = 8'b10_11_10_00;
    wait_cyc(2);

    // ch0 rise: pulse exactly after edge 6, falling edge ignored
    data_in[0] = 1'b1;
    push(4'b0001, 4'b0001, 4'b0001, 8'h01, 6);
    wait_cyc(5);
    chk("t1_pulse_early", 32'(pulse), 32'h0);
    chk("t1_level_early", 32'(level), 32'h0);
    wait_cyc(1);
    chk("t1_pulse_on_time", 32'(pulse), 32'h1);
    wait_cyc(1);
    chk("t1_pulse_one_wide", 32'(pulse), 32'h0);
    wait_cyc(3);
    data_in[0] = 1'b0;
    wait_cyc(8);
    chk("t1_level_fall", 32'(level), 32'h0);
    chk("t1_count_hold", 32'(edge_count), 32'h01);

    // ch1 both: 3-cycle glitch rejected, then a real high pulse
    data_in[1] = 1'b1;
    wait_cyc(3);
    data_in[1] = 1'b0;
    wait_cyc(10);
    chk("t2_glitch_level", 32'(level), 32'h0);
    data_in[1] = 1'b1;
    push(4'b0010, 4'b0011, 4'b0010, 8'b00_00_01_01, 6);
    wait_cyc(10);
    data_in[1] = 1'b0;
    push(4'b0010, 4'b0011, 4'b0000, 8'b00_00_10_01, 6);
    wait_cyc(10);
    chk("t2_count", 32'(edge_count), 32'h09);

    // ch2 off: level tracks, never pulses; then fall mode pulses
    for (int k = 0; k < 5; k++) begin
      data_in[2] = ~data_in[2];
      wait_cyc(10);
      chk("t3_level_tracks", 32'(level[2]), (k % 2 == 0) ? 32'd1 : 32'd0);
    end
    chk("t3_count_zero", 32'(edge_count[5:4]), 32'h0);
    mode[5:4] = 2'b01;
    data_in[2] = 1'b0;
    push(4'b0100, 4'b0111, 4'b0000, 8'h19, 6);
    wait_cyc(10);

    // ch3 both: counter saturates at 3, then same-edge clear and pulse
    for (int k = 0; k < 5; k++) begin
      logic [1:0] cv;
      cv = (k < 3) ? 2'(k + 1) : 2'd3;
      data_in[3] = ~data_in[3];
      push(4'b1000, 4'b1111, (k % 2 == 0) ? 4'b1000 : 4'b0000, {cv, 6'h19}, 6);
      wait_cyc(10);
    end
    data_in[3] = 1'b0;
    push(4'b1000, 4'b1111, 4'b0000, 8'h59, 6);
    wait_cyc(5);
    clear[3] = 1'b1;
    wait_cyc(1);
    clear[3] = 1'b0;
    wait_cyc(4);
    clear[3] = 1'b1;
    wait_cyc(1);
    clear[3] = 1'b0;
    chk("t4_clear_flag", 32'(event_flag), 32'h7);
    chk("t4_clear_count", 32'(edge_count), 32'h19);

    // all channels rise together in rise mode
    mode = 8'h00;
    data_in = 4'hF;
    push(4'b1111, 4'b1111, 4'b1111, 8'h6E, 6);
    wait_cyc(10);
    data_in = 4'h0;
    wait_cyc(10);
    chk("t5_level_low", 32'(level), 32'h0);

    // reset mid-debounce discards the count; restart after release
    data_in[0] = 1'b1;
    wait_cyc(4);
    reset_n = 1'b0;
    wait_cyc(1);
    chk("t6_rst_level", 32'(level), 32'h0);
    chk("t6_rst_flag", 32'(event_flag), 32'h0);
    chk("t6_rst_count", 32'(edge_count), 32'h0);
    chk("t6_rst_pulse", 32'(pulse), 32'h0);
    reset_n = 1'b1;
    push(4'b0001, 4'b0001, 4'b0001, 8'h01, 6);
    wait_cyc(5);
    chk("t6_no_early_pulse", 32'(pulse), 32'h0);
    wait_cyc(6);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_edge_detector.md
Name: multi_edge_detector

Overview:
Parametrised successor to the single-bit falling-edge pulser. It takes NUM_CH asynchronous inputs such as ADC ready/busy lines and buttons. Each channel is synchronised, debounced, and edge-detected with a per-channel mode (rise/fall/both/off). Outputs per channel: 1-clk pulse, sticky event flag with clear, and saturating edge counter. Sits between raw ADC/board signals and the control FSMs.

Parameters:
NUM_CH, 4, number of independent channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required to accept a new level (>=1; 1 = no filtering)
CNT_W, 8, width of each per-channel edge counter (>=1)

Ports:
clk  in  1  system clock; all logic on posedge
reset_n  in  1  synchronous reset, active-low
data_in  in  NUM_CH  asynchronous raw inputs
mode  in  2*NUM_CH  per-channel mode, channel i in bits [2i+1:2i]; 00 rise, 01 fall, 10 both, 11 off
clear  in  NUM_CH  per-channel clear of event_flag and edge_count
level  out  NUM_CH  debounced level per channel
pulse  out  NUM_CH  1-clk registered pulse per accepted, mode-enabled edge
event_flag  out  NUM_CH  sticky: set by pulse, cleared by clear
edge_count  out  CNT_W*NUM_CH  per-channel saturating count of pulses, channel i in [CNT_W*(i+1)-1:CNT_W*i]
any_pulse  out  1  registered OR of all pulse bits, same cycle as pulse

Behaviour:
- Reset: on a posedge with reset_n=0, every flop clears. This covers sync chain, debounce counter, level, pulse, event_flag, edge_count, and any_pulse, all outputs 0 the following cycle. Reset mid-operation discards any in-progress debounce count.
- Synchroniser: plain SYNC_STAGES shift chain. s = last stage output.
- Debounce, per channel, using counter dcnt of width clog2(DEBOUNCE_CYCLES)+1:
  - s == level: dcnt <= 0.
  - s != level and dcnt == DEBOUNCE_CYCLES-1: level <= s, dcnt <= 0, edge accepted this edge.
  - Otherwise dcnt <= dcnt+1.
  - Any return of s to level before acceptance restarts the count (glitch rejected).
- Latency: data_in changes before edge 1 and is held. level and pulse update at edge SYNC_STAGES+DEBOUNCE_CYCLES and are high in the cycle after it. Defaults: edge 6.
- Edge qualification, evaluated at the acceptance edge:
  - rise = s&~level; fall = ~s&level.
  - pulse <= (mode 00 & rise) | (mode 01 & fall) | (mode 10 & (rise|fall)); mode 11 never pulses.
  - pulse is otherwise 0, so it is exactly one cycle wide.
  - mode is sampled only at the acceptance edge. A mode change during a debounce count does not reset it. level always tracks regardless of mode.
- Reset-release: level starts at 0. An input held high through reset produces a rising acceptance SYNC_STAGES+DEBOUNCE_CYCLES edges after reset release (pulse if mode allows).
- event_flag[i]: registered.
  - Set wins on simultaneous clear and pulse, so no event is lost.
  - Clear alone -> 0; pulse alone -> 1; neither -> hold.
- edge_count[i]:
  - Same-edge clear and pulse -> 1.
  - Clear alone -> 0.
  - Pulse alone -> +1, saturating at 2^CNT_W-1 (no wrap).
  - Both event_flag and edge_count are updated from the pulse's next-state value, so they reflect a pulse in the same cycle pulse is high.
- any_pulse: registered from the same next-state values as pulse; zero extra latency.
- Channels are fully independent; simultaneous edges on all channels are all reported.

Decomposition:
- Package edge_det_pkg:
  - mode_e enum (MODE_RISE=2'b00, MODE_FALL=2'b01, MODE_BOTH=2'b10, MODE_OFF=2'b11).
  - Localparam helper for debounce counter width.
- Sub-module edge_det_channel: one channel containing sync chain, debounce, qualification, flag, and counter, with ports clk, reset_n, data_in, mode, clear, level, pulse, event_flag, edge_count.
- Top instantiates NUM_CH copies via generate and ORs the next-state pulses for any_pulse.

Test Plan:
1. Defaults, ch0 mode 00, data_in[0] 0->1 held -> pulse[0] high one cycle after edge 6, level[0]=1, event_flag[0]=1, edge_count[0]=1; then 1->0 -> no pulse, level[0]=0.
2. ch1 mode 10, data_in[1] high 3 cycles then low -> no pulse, level unchanged (glitch reject). Then high 10 cycles then low -> two pulses, edge_count[1]=2.
3. ch2 mode 11 toggled 5 times (each held 10 cycles) -> pulse[2] never high, level[2] follows, count 0. Switch to mode 01 -> next falling acceptance pulses.
4. CNT_W=2, ch3 mode 10, 5 accepted edges -> edge_count[3] 1,2,3,3,3. Assert clear[3] in the same cycle as the 6th pulse -> count=1, flag=1. Clear alone -> 0, 0.
5. All four channels rise simultaneously, mode 00 -> pulse=4'hF and any_pulse=1 in the same cycle.
6. reset_n low for 1 edge while ch0 dcnt=2 -> all outputs 0 next cycle, no pulse. With data_in[0] held high, pulse after 6 more edges.
